// File: rtl/rambus_reader_pkg.sv
// Shared definitions for the rambus stream reader.
//   state_e        : reader FSM encoding
//   RAM_WORDS      : number of 32-bit words in the OpenRAM
//   TIMEOUT_CYCLES : REQ cycles without ack before the optional timeout fires
//   SEL_ALL        : full-word byte select
package rambus_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_GAP   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int         RAM_WORDS      = 256;
  localparam int         TIMEOUT_CYCLES = 16;
  localparam logic [3:0] SEL_ALL        = 4'hF;

endpackage

// File: rtl/rambus_stream_reader_if.sv
// Wishbone port-B bundle between the stream reader (master) and the
// OpenRAM wrapper (slave).
//   clk/rst_o : forwarded clock and reset for the slave
//   stb/cyc   : read request, we/sel/dat_o constant for read-only use
//   adr_o     : byte address, ack_i/dat_i : read response
interface rambus_stream_reader_if;
  logic        rambus_wb_clk_o;
  logic        rambus_wb_rst_o;
  logic        rambus_wb_stb_o;
  logic        rambus_wb_cyc_o;
  logic        rambus_wb_we_o;
  logic [3:0]  rambus_wb_sel_o;
  logic [31:0] rambus_wb_dat_o;
  logic [9:0]  rambus_wb_adr_o;
  logic        rambus_wb_ack_i;
  logic [31:0] rambus_wb_dat_i;

  modport master (
    output rambus_wb_clk_o, rambus_wb_rst_o, rambus_wb_stb_o, rambus_wb_cyc_o,
           rambus_wb_we_o, rambus_wb_sel_o, rambus_wb_dat_o, rambus_wb_adr_o,
    input  rambus_wb_ack_i, rambus_wb_dat_i
  );

  modport slave (
    input  rambus_wb_clk_o, rambus_wb_rst_o, rambus_wb_stb_o, rambus_wb_cyc_o,
           rambus_wb_we_o, rambus_wb_sel_o, rambus_wb_dat_o, rambus_wb_adr_o,
    output rambus_wb_ack_i, rambus_wb_dat_i
  );
endinterface

// File: rtl/rambus_reader_fifo.sv
// Synchronous output FIFO for the stream reader.
//   push/push_data : write side, pop : read side (ignored when empty)
//   flush          : empties the FIFO, wins over push/pop
//   pop_data/valid : head entry (zero when empty), count : occupancy
// A push while full is accepted only together with a pop.
module rambus_reader_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [CW-1:0]    count
);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok, push_ok;

  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && ((count_q != CNT_FULL) || pop_ok);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr_q] <= push_data;
  end

  assign valid    = (count_q != '0);
  assign pop_data = valid ? mem[rd_ptr_q] : '0;
  assign count    = count_q;
endmodule

// File: rtl/rambus_stream_reader.sv
// Wishbone read master for OpenRAM port B: fetches a window of words
// starting at base_addr and plays them out on a valid/ready stream.
//   wb_clk_i/wb_rst_i : clock, async active-high reset
//   start/abort       : control pulses (abort wins), base_addr/length/loop
//   rambus            : Wishbone master bundle
//   m_data/m_valid/m_ready : output stream
//   busy/done/error   : status
// Optional macro RAMBUS_READER_TIMEOUT_EN: abandon a read after 16 cycles
// without ack and flag a sticky error.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_REQ   | read cycle on the bus, held until ack
// ST_GAP   | bus idle, waiting for a free FIFO slot
// ST_DRAIN | all words fetched, waiting for FIFO to empty
module rambus_stream_reader
  import rambus_reader_pkg::*;
#(
  parameter int WORD_ADDR_W = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   start,
  input  logic                   abort,
  input  logic [WORD_ADDR_W-1:0] base_addr,
  input  logic [WORD_ADDR_W:0]   length,
  input  logic                   loop,
  rambus_stream_reader_if.master rambus,
  output logic [31:0]            m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);
  localparam int                   CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [WORD_ADDR_W:0] LEN_MAX  = {1'b1, {WORD_ADDR_W{1'b0}}};
  localparam logic [WORD_ADDR_W:0] OFF_ONE  = {{WORD_ADDR_W{1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [WORD_ADDR_W-1:0] base_q, base_d;
  logic [WORD_ADDR_W:0]   len_q, len_d, offset_q, offset_d, offset_inc;
  logic                   loop_q, loop_d, done_q, done_d;
  logic                   abort_pend_q, abort_pend_d;
  logic                   push, flush;
  logic [CNT_W-1:0]       fifo_count;
  logic [WORD_ADDR_W-1:0] word_idx;
`ifdef RAMBUS_READER_TIMEOUT_EN
  localparam logic [3:0]  TMO_LOAD = 4'(TIMEOUT_CYCLES - 1);
  logic [3:0]             tmo_q, tmo_d;
  logic                   error_q, error_d;
`endif

  assign offset_inc = offset_q + OFF_ONE;
  // Natural wrap of the word index past the top of the RAM.
  assign word_idx   = base_q + offset_q[WORD_ADDR_W-1:0];

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    len_d        = len_q;
    offset_d     = offset_q;
    loop_d       = loop_q;
    done_d       = 1'b0;
    abort_pend_d = abort_pend_q;
    push         = 1'b0;
    flush        = 1'b0;
`ifdef RAMBUS_READER_TIMEOUT_EN
    tmo_d        = tmo_q;
    error_d      = error_q;
`endif
    case (state_q)
      ST_IDLE: begin
        abort_pend_d = 1'b0;
        if (start && !abort) begin
          base_d   = base_addr;
          len_d    = (length > LEN_MAX) ? LEN_MAX : length;
          loop_d   = loop;
          offset_d = '0;
`ifdef RAMBUS_READER_TIMEOUT_EN
          error_d  = 1'b0;
          tmo_d    = TMO_LOAD;
`endif
          if (length == '0) done_d  = 1'b1;
          else              state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (rambus.rambus_wb_ack_i) begin
          // An abort seen during the cycle takes effect once the slave acks.
          if (abort || abort_pend_q) begin
            flush        = 1'b1;
            abort_pend_d = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            push     = 1'b1;
            offset_d = (loop_q && (offset_inc == len_q)) ? '0 : offset_inc;
            state_d  = ST_GAP;
          end
        end else begin
          abort_pend_d = abort_pend_q | abort;
`ifdef RAMBUS_READER_TIMEOUT_EN
          if (tmo_q == '0) begin
            error_d      = 1'b1;
            flush        = 1'b1;
            abort_pend_d = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            tmo_d = tmo_q - 4'd1;
          end
`endif
        end
      end
      ST_GAP: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (!loop_q && (offset_q == len_q)) begin
          state_d = ST_DRAIN;
        end else if (fifo_count != CNT_FULL) begin
          state_d = ST_REQ;
`ifdef RAMBUS_READER_TIMEOUT_EN
          tmo_d   = TMO_LOAD;
`endif
        end
      end
      default: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (fifo_count == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      len_q        <= '0;
      offset_q     <= '0;
      loop_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_pend_q <= 1'b0;
`ifdef RAMBUS_READER_TIMEOUT_EN
      tmo_q        <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      len_q        <= len_d;
      offset_q     <= offset_d;
      loop_q       <= loop_d;
      done_q       <= done_d;
      abort_pend_q <= abort_pend_d;
`ifdef RAMBUS_READER_TIMEOUT_EN
      tmo_q        <= tmo_d;
      error_q      <= error_d;
`endif
    end
  end

  rambus_reader_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .flush     (flush),
    .push      (push),
    .push_data (rambus.rambus_wb_dat_i),
    .pop       (m_ready),
    .pop_data  (m_data),
    .valid     (m_valid),
    .count     (fifo_count)
  );

  // Request is decoded straight from the state flop so reset drops it at once.
  assign rambus.rambus_wb_clk_o = wb_clk_i;
  assign rambus.rambus_wb_rst_o = wb_rst_i;
  assign rambus.rambus_wb_stb_o = (state_q == ST_REQ);
  assign rambus.rambus_wb_cyc_o = (state_q == ST_REQ);
  assign rambus.rambus_wb_we_o  = 1'b0;
  assign rambus.rambus_wb_sel_o = SEL_ALL;
  assign rambus.rambus_wb_dat_o = '0;
  assign rambus.rambus_wb_adr_o = {word_idx, 2'b00};

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
`ifdef RAMBUS_READER_TIMEOUT_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif
endmodule
